// File: rtl/nvdla_cacc_dlv_ctrl_pm_if.sv
// Producer handshake and dbuf read/write bus for the CACC delivery controller.
// The master modport is the controller's view; slave is the surrounding environment.
interface nvdla_cacc_dlv_ctrl_pm_if #(
    parameter int DW = 512,
    parameter int AW = 7
);
    logic          dlv_valid;
    logic          dlv_ready;
    logic [DW-1:0] dlv_data;
    logic [1:0]    dlv_pd;
    logic          dbuf_wr_en;
    logic [AW-1:0] dbuf_wr_addr;
    logic [DW-1:0] dbuf_wr_data;
    logic          dbuf_rd_en;
    logic          dbuf_rd_ready;
    logic [AW-1:0] dbuf_rd_addr;
    logic          dbuf_rd_stripe_end;
    logic          dbuf_rd_layer_end;
    logic          dp2reg_done;
    logic [AW:0]   dbuf_occupancy;

    modport master (
        input  dlv_valid, dlv_data, dlv_pd, dbuf_rd_ready,
        output dlv_ready, dbuf_wr_en, dbuf_wr_addr, dbuf_wr_data,
               dbuf_rd_en, dbuf_rd_addr, dbuf_rd_stripe_end, dbuf_rd_layer_end,
               dp2reg_done, dbuf_occupancy
    );

    modport slave (
        output dlv_valid, dlv_data, dlv_pd, dbuf_rd_ready,
        input  dlv_ready, dbuf_wr_en, dbuf_wr_addr, dbuf_wr_data,
               dbuf_rd_en, dbuf_rd_addr, dbuf_rd_stripe_end, dbuf_rd_layer_end,
               dp2reg_done, dbuf_occupancy
    );
endinterface

// File: rtl/nvdla_cacc_dlv_ctrl_pm.sv
// CACC delivery controller: writes accepted lines into the dbuf, releases them for
// in-order reads after the RAM write latency, and tags stripe/layer ends at read time.
module nvdla_cacc_dlv_ctrl_pm #(
    parameter int DW        = 512,
    parameter int AW        = 7,
    parameter int WR_LAT    = 1,
    parameter int TAG_DEPTH = 4
) (
    input  logic                    nvdla_core_clk,
    input  logic                    nvdla_core_rst,
    nvdla_cacc_dlv_ctrl_pm_if.master bus
);
    localparam int          DEPTH      = 1 << AW;
    localparam int          TW         = $clog2(TAG_DEPTH);
    localparam logic [AW:0] DEPTH_C    = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE    = (AW+1)'(1);
    localparam logic [AW:0] CNT_ZERO   = (AW+1)'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [TW:0] TAG_FULL_C = (TW+1)'(TAG_DEPTH);
    localparam logic [TW:0] TAG_ONE    = (TW+1)'(1);
    localparam logic [TW:0] TAG_ZERO   = (TW+1)'(0);
    localparam logic [TW-1:0] TP_ONE   = TW'(1);

    logic [AW:0]   res_cnt_r;
    logic [AW:0]   avl_cnt_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [WR_LAT:0] mat_sr_r;
    logic          wr_en_r;
    logic [AW-1:0] wr_addr_r;
    logic [DW-1:0] wr_data_r;
    logic          done_r;
    logic [AW-1:0] tag_addr_r [TAG_DEPTH];
    logic [1:0]    tag_pd_r   [TAG_DEPTH];
    logic [TW-1:0] tag_wp_r;
    logic [TW-1:0] tag_rp_r;
    logic [TW:0]   tag_cnt_r;

    logic ready_s, accept_s, rd_en_s, pop_s, matured_s;
    logic tag_push_s, tag_hit_s, stripe_end_s, layer_end_s;

    // Handshake qualifiers and end-tag lookup; ready never looks at dlv_valid or dlv_pd.
    always_comb begin
        ready_s    = (res_cnt_r < DEPTH_C) && (tag_cnt_r < TAG_FULL_C);
        accept_s   = bus.dlv_valid & ready_s;
        rd_en_s    = (avl_cnt_r != CNT_ZERO);
        pop_s      = rd_en_s & bus.dbuf_rd_ready;
        matured_s  = mat_sr_r[WR_LAT];
        tag_push_s = accept_s & (bus.dlv_pd != 2'b00);
        tag_hit_s  = pop_s & (tag_cnt_r != TAG_ZERO) & (rd_ptr_r == tag_addr_r[tag_rp_r]);
        if (tag_hit_s) begin
            stripe_end_s = tag_pd_r[tag_rp_r][0];
            layer_end_s  = tag_pd_r[tag_rp_r][1];
        end else begin
            stripe_end_s = 1'b0;
            layer_end_s  = 1'b0;
        end
    end

    // One-cycle write pipeline into the dbuf plus the layer-done pulse.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= {AW{1'b0}};
            wr_data_r <= {DW{1'b0}};
            wr_ptr_r  <= {AW{1'b0}};
            done_r    <= 1'b0;
        end else begin
            wr_en_r <= accept_s;
            done_r  <= accept_s & bus.dlv_pd[0] & bus.dlv_pd[1];
            if (accept_s) begin
                wr_addr_r <= wr_ptr_r;
                wr_data_r <= bus.dlv_data;
                wr_ptr_r  <= wr_ptr_r + PTR_ONE;
            end
        end
    end

    // Accept travels WR_LAT+1 stages before the entry counts as readable.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            mat_sr_r <= {(WR_LAT+1){1'b0}};
        end else begin
            mat_sr_r[0] <= accept_s;
            for (int i = 1; i <= WR_LAT; i++) begin
                mat_sr_r[i] <= mat_sr_r[i-1];
            end
        end
    end

    // Reserved and readable counters plus the in-order read pointer.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            res_cnt_r <= CNT_ZERO;
            avl_cnt_r <= CNT_ZERO;
            rd_ptr_r  <= {AW{1'b0}};
        end else begin
            case ({accept_s, pop_s})
                2'b10:   res_cnt_r <= res_cnt_r + CNT_ONE;
                2'b01:   res_cnt_r <= res_cnt_r - CNT_ONE;
                default: res_cnt_r <= res_cnt_r;
            endcase
            case ({matured_s, pop_s})
                2'b10:   avl_cnt_r <= avl_cnt_r + CNT_ONE;
                2'b01:   avl_cnt_r <= avl_cnt_r - CNT_ONE;
                default: avl_cnt_r <= avl_cnt_r;
            endcase
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // End-tag FIFO: holds the dbuf address and pd of every tagged line until it is read.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_addr_r[i] <= {AW{1'b0}};
                tag_pd_r[i]   <= 2'b00;
            end
            tag_wp_r  <= {TW{1'b0}};
            tag_rp_r  <= {TW{1'b0}};
            tag_cnt_r <= TAG_ZERO;
        end else begin
            if (tag_push_s) begin
                tag_addr_r[tag_wp_r] <= wr_ptr_r;
                tag_pd_r[tag_wp_r]   <= bus.dlv_pd;
                tag_wp_r             <= tag_wp_r + TP_ONE;
            end
            if (tag_hit_s) begin
                tag_rp_r <= tag_rp_r + TP_ONE;
            end
            case ({tag_push_s, tag_hit_s})
                2'b10:   tag_cnt_r <= tag_cnt_r + TAG_ONE;
                2'b01:   tag_cnt_r <= tag_cnt_r - TAG_ONE;
                default: tag_cnt_r <= tag_cnt_r;
            endcase
        end
    end

    assign bus.dlv_ready          = ready_s;
    assign bus.dbuf_wr_en         = wr_en_r;
    assign bus.dbuf_wr_addr       = wr_addr_r;
    assign bus.dbuf_wr_data       = wr_data_r;
    assign bus.dbuf_rd_en         = rd_en_s;
    assign bus.dbuf_rd_addr       = rd_ptr_r;
    assign bus.dbuf_rd_stripe_end = stripe_end_s;
    assign bus.dbuf_rd_layer_end  = layer_end_s;
    assign bus.dp2reg_done        = done_r;
    assign bus.dbuf_occupancy     = res_cnt_r;
endmodule

// File: tb/tb_nvdla_cacc_dlv_ctrl_pm.sv
// Directed self-checking bench for nvdla_cacc_dlv_ctrl_pm (main instance WR_LAT=1,
// plus five small instances sweeping WR_LAT 0..4 for read latency).
module tb_nvdla_cacc_dlv_ctrl_pm;
    localparam int DW = 512;
    localparam int AW = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [DW-1:0] pat;
    logic [AW-1:0] exp_rd;
    logic [AW-1:0] exp_wa;
    int   npop;

    always #5 clk = ~clk;

    nvdla_cacc_dlv_ctrl_pm_if #(.DW(DW), .AW(AW)) bus();
    nvdla_cacc_dlv_ctrl_pm #(.DW(DW), .AW(AW), .WR_LAT(1), .TAG_DEPTH(4)) dut (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst), .bus(bus));

    logic       lat_valid;
    logic [4:0] lat_rd_en;
    for (genvar g = 0; g < 5; g++) begin : g_lat
        nvdla_cacc_dlv_ctrl_pm_if #(.DW(8), .AW(3)) lif();
        assign lif.dlv_valid     = lat_valid;
        assign lif.dlv_data      = 8'h3C;
        assign lif.dlv_pd        = 2'b00;
        assign lif.dbuf_rd_ready = 1'b1;
        assign lat_rd_en[g]      = lif.dbuf_rd_en;
        nvdla_cacc_dlv_ctrl_pm #(.DW(8), .AW(3), .WR_LAT(g), .TAG_DEPTH(2)) u_dut (
            .nvdla_core_clk(clk), .nvdla_core_rst(rst), .bus(lif));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drain with reads enabled and no writes; checks address order and that no tags fire.
    task automatic drain_plain(input logic [AW-1:0] start, input int expect_pops, input string tag);
        exp_rd = start;
        npop   = 0;
        bus.dlv_valid     = 1'b0;
        bus.dbuf_rd_ready = 1'b1;
        for (int k = 0; k < 300 && bus.dbuf_occupancy != 8'd0; k++) begin
            #1;
            if (bus.dbuf_rd_en) begin
                checks++;
                if (bus.dbuf_rd_addr !== exp_rd || bus.dbuf_rd_stripe_end !== 1'b0 || bus.dbuf_rd_layer_end !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_pop addr=%0d se=%b le=%b exp addr=%0d se=0 le=0", tag,
                             bus.dbuf_rd_addr, bus.dbuf_rd_stripe_end, bus.dbuf_rd_layer_end, exp_rd);
                end
                exp_rd = exp_rd + 7'd1;
                npop++;
            end
            tick();
        end
        checks++;
        if (bus.dbuf_occupancy !== 8'd0 || npop != expect_pops) begin
            errors++;
            $display("FAIL %s_drain occ=%0d pops=%0d exp occ=0 pops=%0d", tag, bus.dbuf_occupancy, npop, expect_pops);
        end
    endtask

    task automatic test_reset();
        bus.dlv_valid     = 1'b0;
        bus.dlv_data      = {DW{1'b0}};
        bus.dlv_pd        = 2'b00;
        bus.dbuf_rd_ready = 1'b0;
        lat_valid         = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.dlv_ready !== 1'b1 || bus.dbuf_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs ready=%b rd_en=%b exp 1 0", bus.dlv_ready, bus.dbuf_rd_en);
        end
        checks++;
        if ({bus.dbuf_wr_en, bus.dp2reg_done, bus.dbuf_rd_stripe_end, bus.dbuf_rd_layer_end} !== 4'b0000 ||
            bus.dbuf_occupancy !== 8'd0 || bus.dbuf_wr_addr !== 7'd0 || bus.dbuf_rd_addr !== 7'd0 ||
            bus.dbuf_wr_data !== {DW{1'b0}}) begin
            errors++;
            $display("FAIL reset_outs wr_en=%b done=%b occ=%0d wa=%0d ra=%0d exp all 0", bus.dbuf_wr_en,
                     bus.dp2reg_done, bus.dbuf_occupancy, bus.dbuf_wr_addr, bus.dbuf_rd_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        pat = {64{8'hA5}};
        bus.dbuf_rd_ready = 1'b1;
        bus.dlv_valid = 1'b1;
        bus.dlv_data  = pat;
        bus.dlv_pd    = 2'b00;
        tick();
        bus.dlv_valid = 1'b0;
        #1;
        checks++;
        if (bus.dbuf_wr_en !== 1'b1 || bus.dbuf_wr_addr !== 7'd0 || bus.dbuf_wr_data !== pat) begin
            errors++;
            $display("FAIL single_wr en=%b addr=%0d exp en=1 addr=0 data=a5..", bus.dbuf_wr_en, bus.dbuf_wr_addr);
        end
        checks++;
        if (bus.dbuf_occupancy !== 8'd1 || bus.dbuf_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL single_t1 occ=%0d rd_en=%b exp 1 0", bus.dbuf_occupancy, bus.dbuf_rd_en);
        end
        tick();
        checks++;
        if (bus.dbuf_rd_en !== 1'b0 || bus.dbuf_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL single_t2 rd_en=%b wr_en=%b exp 0 0", bus.dbuf_rd_en, bus.dbuf_wr_en);
        end
        tick();
        checks++;
        if (bus.dbuf_rd_en !== 1'b1 || bus.dbuf_rd_addr !== 7'd0) begin
            errors++;
            $display("FAIL single_t3 rd_en=%b addr=%0d exp 1 0", bus.dbuf_rd_en, bus.dbuf_rd_addr);
        end
        tick();
        checks++;
        if (bus.dbuf_occupancy !== 8'd0 || bus.dbuf_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL single_t4 occ=%0d rd_en=%b exp 0 0", bus.dbuf_occupancy, bus.dbuf_rd_en);
        end
    endtask

    task automatic test_fill();
        bus.dbuf_rd_ready = 1'b0;
        bus.dlv_pd = 2'b00;
        for (int i = 0; i < 128; i++) begin
            bus.dlv_valid = 1'b1;
            bus.dlv_data  = DW'(i);
            #1;
            checks++;
            if (bus.dlv_ready !== 1'b1) begin
                errors++;
                $display("FAIL fill_ready i=%0d got 0 exp 1", i);
            end
            tick();
            exp_wa = AW'(i + 1);
            checks++;
            if (bus.dbuf_wr_en !== 1'b1 || bus.dbuf_wr_addr !== exp_wa) begin
                errors++;
                $display("FAIL fill_waddr i=%0d addr=%0d exp %0d", i, bus.dbuf_wr_addr, exp_wa);
            end
        end
        #1;
        checks++;
        if (bus.dlv_ready !== 1'b0 || bus.dbuf_occupancy !== 8'd128) begin
            errors++;
            $display("FAIL fill_full ready=%b occ=%0d exp 0 128", bus.dlv_ready, bus.dbuf_occupancy);
        end
        checks++;
        if (bus.dbuf_rd_en !== 1'b1 || bus.dbuf_rd_addr !== 7'd1) begin
            errors++;
            $display("FAIL fill_hold rd_en=%b addr=%0d exp 1 1", bus.dbuf_rd_en, bus.dbuf_rd_addr);
        end
        tick();
        checks++;
        if (bus.dbuf_wr_en !== 1'b0 || bus.dbuf_rd_addr !== 7'd1) begin
            errors++;
            $display("FAIL fill_stall wr_en=%b ra=%0d exp 0 1", bus.dbuf_wr_en, bus.dbuf_rd_addr);
        end
        bus.dbuf_rd_ready = 1'b1;
        tick();
        bus.dbuf_rd_ready = 1'b0;
        #1;
        checks++;
        if (bus.dlv_ready !== 1'b1 || bus.dbuf_occupancy !== 8'd127) begin
            errors++;
            $display("FAIL fill_reopen ready=%b occ=%0d exp 1 127", bus.dlv_ready, bus.dbuf_occupancy);
        end
        tick();
        bus.dlv_valid = 1'b0;
        checks++;
        if (bus.dbuf_wr_en !== 1'b1 || bus.dbuf_wr_addr !== 7'd1) begin
            errors++;
            $display("FAIL fill_wrap_wr en=%b addr=%0d exp 1 1", bus.dbuf_wr_en, bus.dbuf_wr_addr);
        end
        drain_plain(7'd2, 128, "fill");
    endtask

    task automatic test_tags();
        logic exp_done;
        logic exp_se;
        logic exp_le;
        int   saw5;
        int   saw9;
        exp_done = 1'b0;
        saw5 = 0;
        saw9 = 0;
        exp_rd = 7'd2;
        bus.dbuf_rd_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            bus.dlv_valid = (c < 8);
            bus.dlv_pd    = (c == 3) ? 2'b01 : ((c == 7) ? 2'b11 : 2'b00);
            bus.dlv_data  = DW'(c + 100);
            #1;
            checks++;
            if (bus.dp2reg_done !== exp_done) begin
                errors++;
                $display("FAIL tags_done c=%0d got %b exp %b", c, bus.dp2reg_done, exp_done);
            end
            exp_se = 1'b0;
            exp_le = 1'b0;
            if (bus.dbuf_rd_en) begin
                exp_se = (exp_rd == 7'd5) || (exp_rd == 7'd9);
                exp_le = (exp_rd == 7'd9);
                checks++;
                if (bus.dbuf_rd_addr !== exp_rd) begin
                    errors++;
                    $display("FAIL tags_raddr got %0d exp %0d", bus.dbuf_rd_addr, exp_rd);
                end
                if (exp_rd == 7'd5 && bus.dbuf_rd_stripe_end === 1'b1) saw5++;
                if (exp_rd == 7'd9 && bus.dbuf_rd_layer_end === 1'b1) saw9++;
                exp_rd = exp_rd + 7'd1;
            end
            checks++;
            if (bus.dbuf_rd_stripe_end !== exp_se || bus.dbuf_rd_layer_end !== exp_le) begin
                errors++;
                $display("FAIL tags_end c=%0d se=%b le=%b exp %b %b", c, bus.dbuf_rd_stripe_end,
                         bus.dbuf_rd_layer_end, exp_se, exp_le);
            end
            exp_done = (c == 7);
            tick();
        end
        bus.dlv_pd = 2'b00;
        checks++;
        if (saw5 != 1 || saw9 != 1 || bus.dbuf_occupancy !== 8'd0) begin
            errors++;
            $display("FAIL tags_seen s5=%0d s9=%0d occ=%0d exp 1 1 0", saw5, saw9, bus.dbuf_occupancy);
        end
    endtask

    task automatic test_tag_full();
        bus.dbuf_rd_ready = 1'b0;
        bus.dlv_valid = 1'b1;
        bus.dlv_pd    = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        #1;
        checks++;
        if (bus.dlv_ready !== 1'b0 || bus.dbuf_occupancy !== 8'd4) begin
            errors++;
            $display("FAIL tagfull_block ready=%b occ=%0d exp 0 4", bus.dlv_ready, bus.dbuf_occupancy);
        end
        tick();
        bus.dbuf_rd_ready = 1'b1;
        #1;
        checks++;
        if (bus.dbuf_rd_addr !== 7'd10 || bus.dbuf_rd_stripe_end !== 1'b1 || bus.dbuf_rd_layer_end !== 1'b0) begin
            errors++;
            $display("FAIL tagfull_pop1 addr=%0d se=%b le=%b exp 10 1 0", bus.dbuf_rd_addr,
                     bus.dbuf_rd_stripe_end, bus.dbuf_rd_layer_end);
        end
        tick();
        #1;
        checks++;
        if (bus.dlv_ready !== 1'b1 || bus.dbuf_rd_addr !== 7'd11 || bus.dbuf_rd_stripe_end !== 1'b1) begin
            errors++;
            $display("FAIL tagfull_pushpop ready=%b addr=%0d se=%b exp 1 11 1", bus.dlv_ready,
                     bus.dbuf_rd_addr, bus.dbuf_rd_stripe_end);
        end
        tick();
        bus.dbuf_rd_ready = 1'b0;
        #1;
        checks++;
        if (bus.dlv_ready !== 1'b1 || bus.dbuf_occupancy !== 8'd3) begin
            errors++;
            $display("FAIL tagfull_after ready=%b occ=%0d exp 1 3", bus.dlv_ready, bus.dbuf_occupancy);
        end
        tick();
        bus.dlv_valid = 1'b0;
        #1;
        checks++;
        if (bus.dlv_ready !== 1'b0 || bus.dbuf_occupancy !== 8'd4) begin
            errors++;
            $display("FAIL tagfull_refill ready=%b occ=%0d exp 0 4", bus.dlv_ready, bus.dbuf_occupancy);
        end
        exp_rd = 7'd12;
        npop = 0;
        bus.dbuf_rd_ready = 1'b1;
        for (int k = 0; k < 20 && bus.dbuf_occupancy != 8'd0; k++) begin
            #1;
            if (bus.dbuf_rd_en) begin
                checks++;
                if (bus.dbuf_rd_addr !== exp_rd || bus.dbuf_rd_stripe_end !== 1'b1 || bus.dbuf_rd_layer_end !== 1'b0) begin
                    errors++;
                    $display("FAIL tagfull_drain addr=%0d se=%b le=%b exp %0d 1 0", bus.dbuf_rd_addr,
                             bus.dbuf_rd_stripe_end, bus.dbuf_rd_layer_end, exp_rd);
                end
                exp_rd = exp_rd + 7'd1;
                npop++;
            end
            tick();
        end
        bus.dlv_pd = 2'b00;
        checks++;
        if (npop != 4 || bus.dbuf_occupancy !== 8'd0) begin
            errors++;
            $display("FAIL tagfull_count pops=%0d occ=%0d exp 4 0", npop, bus.dbuf_occupancy);
        end
    endtask

    task automatic test_back_to_back();
        bus.dbuf_rd_ready = 1'b1;
        bus.dlv_pd = 2'b00;
        for (int i = 0; i < 30; i++) begin
            bus.dlv_valid = 1'b1;
            bus.dlv_data  = DW'(i);
            #1;
            if (i >= 3) begin
                checks++;
                if (bus.dbuf_occupancy !== 8'd3 || bus.dbuf_rd_en !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_steady i=%0d occ=%0d rd_en=%b exp 3 1", i, bus.dbuf_occupancy, bus.dbuf_rd_en);
                end
            end
            tick();
        end
        drain_plain(7'd43, 3, "b2b");
    endtask

    task automatic test_mid_reset();
        bus.dbuf_rd_ready = 1'b0;
        for (int i = 0; i < 50; i++) begin
            bus.dlv_valid = 1'b1;
            bus.dlv_pd    = (i == 10 || i == 30) ? 2'b10 : 2'b00;
            tick();
        end
        bus.dlv_pd = 2'b00;
        #1;
        checks++;
        if (bus.dbuf_occupancy !== 8'd50) begin
            errors++;
            $display("FAIL midrst_pre occ=%0d exp 50", bus.dbuf_occupancy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.dlv_ready !== 1'b1 || bus.dbuf_occupancy !== 8'd0 || bus.dbuf_wr_en !== 1'b0 ||
            bus.dbuf_rd_en !== 1'b0 || bus.dbuf_wr_addr !== 7'd0 || bus.dbuf_wr_data !== {DW{1'b0}}) begin
            errors++;
            $display("FAIL midrst_outs ready=%b occ=%0d wr_en=%b rd_en=%b wa=%0d exp 1 0 0 0 0",
                     bus.dlv_ready, bus.dbuf_occupancy, bus.dbuf_wr_en, bus.dbuf_rd_en, bus.dbuf_wr_addr);
        end
        tick();
        bus.dlv_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if (bus.dbuf_wr_en !== 1'b0 || bus.dbuf_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL midrst_post wr_en=%b rd_en=%b exp 0 0", bus.dbuf_wr_en, bus.dbuf_rd_en);
        end
        exp_rd = 7'd0;
        npop = 0;
        bus.dbuf_rd_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            bus.dlv_valid = (c < 80);
            #1;
            if (c == 1) begin
                checks++;
                if (bus.dbuf_wr_en !== 1'b1 || bus.dbuf_wr_addr !== 7'd0) begin
                    errors++;
                    $display("FAIL midrst_waddr en=%b addr=%0d exp 1 0", bus.dbuf_wr_en, bus.dbuf_wr_addr);
                end
            end
            if (bus.dbuf_rd_en) begin
                checks++;
                if (bus.dbuf_rd_addr !== exp_rd || bus.dbuf_rd_stripe_end !== 1'b0 || bus.dbuf_rd_layer_end !== 1'b0) begin
                    errors++;
                    $display("FAIL midrst_pop addr=%0d se=%b le=%b exp %0d 0 0", bus.dbuf_rd_addr,
                             bus.dbuf_rd_stripe_end, bus.dbuf_rd_layer_end, exp_rd);
                end
                exp_rd = exp_rd + 7'd1;
                npop++;
            end
            tick();
        end
        checks++;
        if (npop != 80 || bus.dbuf_occupancy !== 8'd0) begin
            errors++;
            $display("FAIL midrst_count pops=%0d occ=%0d exp 80 0", npop, bus.dbuf_occupancy);
        end
    endtask

    task automatic test_wr_lat();
        int first [5];
        for (int g = 0; g < 5; g++) first[g] = -1;
        lat_valid = 1'b1;
        tick();
        lat_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            #1;
            for (int g = 0; g < 5; g++) begin
                if (first[g] < 0 && lat_rd_en[g] === 1'b1) first[g] = k;
            end
            tick();
        end
        for (int g = 0; g < 5; g++) begin
            checks++;
            if (first[g] != g + 2) begin
                errors++;
                $display("FAIL wrlat_%0d latency=%0d exp %0d", g, first[g], g + 2);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_tags();
        test_tag_full();
        test_back_to_back();
        test_mid_reset();
        test_wr_lat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
